i2s_bram_capture: RTL and testbench

Record-path counterpart to the BRAM playback DMA. It accepts a stream of signed 16-bit audio samples, buffers them in a small FIFO, and writes them sequentially into the PS-shared BRAM, one sample per 32-bit word. The software side later reads back or replays the clip. Capture is armed by a pulse and reports done/overflow status.

---
 rtl/i2s_bram_capture.sv | 103 ++++++++++
 tb/tb_i2s_bram_capture.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_bram_capture.sv
// i2s_bram_capture: buffers signed 16-bit samples in a small FIFO and writes them
// sequentially into PS-shared BRAM, one sign-extended sample per 32-bit word.
module i2s_bram_capture #(
    parameter int NUM_WORDS           = 256,
    parameter int CAPTURE_LEN         = NUM_WORDS,
    parameter int FIFO_DEPTH          = 8,
    parameter int BRAM_ADDR_INCREMENT = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] BRAM_addr,
    output logic        BRAM_clk,
    output logic [31:0] BRAM_din,
    input  logic [31:0] BRAM_dout,
    output logic        BRAM_en,
    output logic        BRAM_rst,
    output logic [3:0]  BRAM_we,
    input  logic        arm,
    input  logic        sample_valid,
    input  logic [15:0] sample_in,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [15:0] words_written
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LEN = (CAPTURE_LEN < NUM_WORDS) ? CAPTURE_LEN : NUM_WORDS;

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t        state, state_nxt;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [15:0]   accepted;
    logic          full, empty, room, push, pop, drop, start, fin;
    logic          unused_dout;

    assign BRAM_clk    = clk;
    assign unused_dout = ^BRAM_dout;
    assign full        = count == (AW+1)'(FIFO_DEPTH);
    assign empty       = count == '0;
    assign room        = accepted < 16'(LEN);
    assign start       = (state != CAPTURE) && arm;
    // full comes from registered occupancy, so a same-cycle pop never rescues a push
    assign push        = (state == CAPTURE) && sample_valid && room && !full;
    assign drop        = (state == CAPTURE) && sample_valid && room && full;
    assign pop         = (state == CAPTURE) && !empty;
    assign fin         = (words_written == 16'(LEN)) && empty;

    always_comb begin
        state_nxt = (state != CAPTURE) ? (arm ? CAPTURE : state) : (fin ? DONE : CAPTURE);
        busy      = state == CAPTURE;
        done      = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sample_in;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            accepted      <= '0;
            words_written <= '0;
            overflow      <= 1'b0;
            BRAM_addr     <= '0;
            BRAM_din      <= '0;
            BRAM_en       <= 1'b0;
            BRAM_we       <= '0;
            BRAM_rst      <= 1'b1;
        end else begin
            state    <= state_nxt;
            BRAM_rst <= 1'b0;
            BRAM_en  <= pop;
            BRAM_we  <= {4{pop}};
            if (start) begin
                rd_ptr        <= '0;
                wr_ptr        <= '0;
                count         <= '0;
                accepted      <= '0;
                words_written <= '0;
                overflow      <= 1'b0;
            end else begin
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
                if (push) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    accepted <= accepted + 16'd1;
                end
                if (pop) begin
                    rd_ptr        <= rd_ptr + 1'b1;
                    words_written <= words_written + 16'd1;
                    BRAM_addr     <= 32'(words_written) * 32'(BRAM_ADDR_INCREMENT);
                    BRAM_din      <= {{16{mem[rd_ptr][15]}}, mem[rd_ptr]};
                end
                if (drop) overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_i2s_bram_capture.sv
// tb_i2s_bram_capture: two capture instances (4-sample and 256-sample) checked every
// cycle against a sample-list model of the capture, plus literal pins on key results.
module tb_i2s_bram_capture;
    localparam int FD = 8;

    logic        clk = 1'b0;
    logic        rst [2], arm [2], sv [2];
    logic [15:0] sin [2];
    logic [31:0] dout = 32'hDEADBEEF;
    logic        busy [2], done [2], ovf [2], en [2], brst [2], bclk [2];
    logic [15:0] ww [2];
    logic [31:0] addr [2], din [2];
    logic [3:0]  we [2];

    always #5 clk = ~clk;

    i2s_bram_capture #(.CAPTURE_LEN(4)) dut_a (
        .clk(clk), .rst(rst[0]), .BRAM_addr(addr[0]), .BRAM_clk(bclk[0]), .BRAM_din(din[0]),
        .BRAM_dout(dout), .BRAM_en(en[0]), .BRAM_rst(brst[0]), .BRAM_we(we[0]), .arm(arm[0]),
        .sample_valid(sv[0]), .sample_in(sin[0]), .busy(busy[0]), .done(done[0]),
        .overflow(ovf[0]), .words_written(ww[0]));

    i2s_bram_capture dut_b (
        .clk(clk), .rst(rst[1]), .BRAM_addr(addr[1]), .BRAM_clk(bclk[1]), .BRAM_din(din[1]),
        .BRAM_dout(dout), .BRAM_en(en[1]), .BRAM_rst(brst[1]), .BRAM_we(we[1]), .arm(arm[1]),
        .sample_valid(sv[1]), .sample_in(sin[1]), .busy(busy[1]), .done(done[1]),
        .overflow(ovf[1]), .words_written(ww[1]));

    int          tests, fails, cyc;
    int          len [2] = '{4, 256};
    int          st [2], acc [2], w [2];
    bit          m_ovf [2], m_en [2], m_brst [2], hold [2];
    logic [31:0] m_addr [2], m_din [2];
    logic [15:0] acc_s [2][256];
    logic [31:0] la [$], ld [$];
    int          occ;
    bit          fin, chk_on, mon;
    int          n_str, first_c, last_c, acc_c;
    logic [31:0] last_a;
    logic [88:0] act_v, exp_v;
    logic [31:0] ex_d [4] = '{32'h00000001, 32'hFFFF8000, 32'h00007FFF, 32'hFFFFFFFE};
    logic [15:0] xs [6];

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: the k-th accepted sample becomes the k-th write at byte address 4k;
    // FIFO occupancy is simply accepted minus written.
    initial forever begin
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst[i]) begin
                st[i] = 0; acc[i] = 0; w[i] = 0; m_ovf[i] = 0; m_en[i] = 0;
                m_addr[i] = 0; m_din[i] = 0; m_brst[i] = 1;
            end else begin
                m_brst[i] = 0;
                m_en[i]   = 0;
                if (st[i] == 1) begin
                    occ = acc[i] - w[i];
                    fin = (w[i] == len[i]) && (occ == 0);
                    if (occ > 0 && !hold[i]) begin
                        m_en[i]   = 1;
                        m_addr[i] = 32'(w[i] * 4);
                        m_din[i]  = {{16{acc_s[i][w[i]][15]}}, acc_s[i][w[i]]};
                        if (i == 0) begin
                            la.push_back(m_addr[i]);
                            ld.push_back(m_din[i]);
                        end
                        w[i]++;
                    end
                    if (sv[i] && acc[i] < len[i]) begin
                        if (occ < FD) begin
                            acc_s[i][acc[i]] = sin[i];
                            acc[i]++;
                        end else m_ovf[i] = 1;
                    end
                    if (fin) st[i] = 2;
                end else if (arm[i]) begin
                    st[i] = 1; acc[i] = 0; w[i] = 0; m_ovf[i] = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) for (int i = 0; i < 2; i++) begin
            act_v = {busy[i], done[i], ovf[i], ww[i], en[i], we[i], brst[i], addr[i], din[i]};
            exp_v = {st[i] == 1, st[i] == 2, m_ovf[i], 16'(w[i]), m_en[i], {4{m_en[i]}},
                     m_brst[i], m_addr[i], m_din[i]};
            chk($sformatf("outputs_dut%0d", i), 128'(act_v), 128'(exp_v));
        end
    end

    initial forever begin
        @(negedge clk);
        if (mon && en[1]) begin
            if (n_str == 0) first_c = cyc;
            last_c = cyc;
            last_a = addr[1];
            n_str++;
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_arm(int i);
        arm[i] = 1'b1;
        @(negedge clk);
        arm[i] = 1'b0;
    endtask

    task automatic send(int i, logic [15:0] v, int gap);
        sv[i]  = 1'b1;
        sin[i] = v;
        @(negedge clk);
        sv[i] = 1'b0;
        tick(gap);
    endtask

    task automatic wait_done(int i, int bound);
        int k = 0;
        while (!done[i] && k < bound) begin
            tick(1);
            k++;
        end
        chk($sformatf("done_reached_dut%0d", i), 128'(done[i]), 128'(1));
    endtask

    task automatic finish_cap(int i, int bound);
        int k = 0;
        while (!done[i] && k < bound) begin
            send(i, 16'($urandom), 0);
            k++;
        end
        chk($sformatf("done_fed_dut%0d", i), 128'(done[i]), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 0; arm[i] = 0; sv[i] = 0; sin[i] = 0; hold[i] = 0;
        end
        chk_on = 1;
        tick(1);
        send(0, 16'h1234, 1);
        chk("reset_bram_rst", 128'(brst[0]), 128'(1));
        chk("reset_busy", 128'(busy[0]), 128'(0));
        rst[0] = 1; rst[1] = 1;
        tick(1);
        chk("bram_rst_release", 128'(brst[0]), 128'(0));
        chk("idle_no_enable", 128'(en[0]), 128'(0));

        la.delete(); ld.delete();
        pulse_arm(0);
        send(0, 16'h0001, 2);
        send(0, 16'h8000, 2);
        send(0, 16'h7FFF, 2);
        send(0, 16'hFFFE, 2);
        wait_done(0, 20);
        chk("basic_writes", 128'(la.size()), 128'(4));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("basic_addr%0d", k), 128'(la[k]), 128'(4 * k));
            chk($sformatf("basic_din%0d", k), 128'(ld[k]), 128'(ex_d[k]));
        end
        chk("basic_words", 128'(ww[0]), 128'(4));
        chk("basic_busy", 128'(busy[0]), 128'(0));

        la.delete(); ld.delete();
        pulse_arm(0);
        for (int k = 0; k < 6; k++) begin
            xs[k] = 16'($urandom);
            send(0, xs[k], 0);
        end
        wait_done(0, 20);
        chk("excess_writes", 128'(la.size()), 128'(4));
        for (int k = 0; k < 4; k++)
            chk($sformatf("excess_din%0d", k), 128'(ld[k]), 128'({{16{xs[k][15]}}, xs[k]}));
        chk("excess_overflow", 128'(ovf[0]), 128'(0));

        pulse_arm(0);
        send(0, 16'($urandom), 2);
        send(0, 16'($urandom), 2);
        send(0, 16'($urandom), 0);
        rst[0] = 0;
        tick(1);
        chk("abort_words", 128'(ww[0]), 128'(0));
        chk("abort_busy", 128'(busy[0]), 128'(0));
        chk("abort_bram_rst", 128'(brst[0]), 128'(1));
        rst[0] = 1;
        tick(1);
        la.delete(); ld.delete();
        pulse_arm(0);
        send(0, 16'($urandom), 1);
        pulse_arm(0);
        for (int k = 0; k < 3; k++) send(0, 16'($urandom), 1);
        wait_done(0, 20);
        chk("rearm_writes", 128'(la.size()), 128'(4));
        for (int k = 0; k < 4; k++) chk($sformatf("rearm_addr%0d", k), 128'(la[k]), 128'(4 * k));
        chk("rearm_words", 128'(ww[0]), 128'(4));

        repeat (6) begin
            pulse_arm(0);
            for (int c = 0; c < 12; c++) begin
                sv[0]  = 1'($urandom_range(0, 1));
                sin[0] = 16'($urandom);
                arm[0] = (c < 3) && ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
            sv[0] = 0; arm[0] = 0;
            finish_cap(0, 20);
        end

        mon = 1;
        pulse_arm(1);
        acc_c = cyc + 1;
        sv[1] = 1;
        repeat (256) begin
            sin[1] = 16'($urandom);
            @(negedge clk);
        end
        sv[1] = 0;
        wait_done(1, 20);
        mon = 0;
        chk("b2b_strobes", 128'(n_str), 128'(256));
        chk("b2b_latency", 128'(first_c - acc_c), 128'(1));
        chk("b2b_span", 128'(last_c - first_c), 128'(255));
        chk("b2b_last_addr", 128'(last_a), 128'(1020));
        chk("b2b_overflow", 128'(ovf[1]), 128'(0));
        chk("b2b_words", 128'(ww[1]), 128'(256));

        force dut_b.pop = 1'b0;
        hold[1] = 1;
        pulse_arm(1);
        repeat (10) send(1, 16'($urandom), 0);
        release dut_b.pop;
        hold[1] = 0;
        tick(15);
        chk("ovf_flag", 128'(ovf[1]), 128'(1));
        chk("ovf_words", 128'(ww[1]), 128'(8));
        chk("ovf_busy", 128'(busy[1]), 128'(1));
        rst[1] = 0;
        tick(1);
        chk("ovf_reset_flag", 128'(ovf[1]), 128'(0));
        chk("ovf_reset_words", 128'(ww[1]), 128'(0));
        rst[1] = 1;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
